// File: rtl/seq_control_unit.sv
// rtl/seq_control_unit.sv - multi-cycle instruction sequencer with valid/ready fetch
// Decodes a latched instruction word into datapath controls over one or two execute cycles.
module seq_control_unit #(
  parameter int INST_W    = 8,
  parameter int REG_SEL_W = 3,
  parameter int ALU_SEL_W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [INST_W-1:0]    inst,
  input  logic                 instValid,
  output logic                 instReady,
  output logic [ALU_SEL_W-1:0] aluSel,
  output logic [REG_SEL_W-1:0] regInSel,
  output logic [REG_SEL_W-1:0] regOutSel,
  output logic                 regInEn,
  output logic                 regOutEn,
  output logic                 genConst,
  output logic                 loadAddr,
  output logic                 aluLatch,
  output logic                 busy,
  output logic                 halted,
  output logic                 illegal
);

  localparam int OP_W = INST_W - REG_SEL_W;

  localparam logic [1:0] S_FETCH = 2'd0;
  localparam logic [1:0] S_EXEC1 = 2'd1;
  localparam logic [1:0] S_EXEC2 = 2'd2;
  localparam logic [1:0] S_HALT  = 2'd3;

  localparam logic [OP_W-1:0] OP_NOP    = OP_W'(0);
  localparam logic [OP_W-1:0] OP_MOV_RR = OP_W'(1);
  localparam logic [OP_W-1:0] OP_MOV_R0 = OP_W'(2);
  localparam logic [OP_W-1:0] OP_LDI    = OP_W'(3);
  localparam logic [OP_W-1:0] OP_LDA    = OP_W'(4);
  localparam logic [OP_W-1:0] OP_HLT    = OP_W'(7);

  logic [1:0]           state;
  logic [1:0]           next_state;
  logic [INST_W-1:0]    ir;
  logic [OP_W-1:0]      op;
  logic [REG_SEL_W-1:0] r;

  assign op = ir[INST_W-1:REG_SEL_W];
  assign r  = ir[REG_SEL_W-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_FETCH;
      ir    <= '0;
    end else begin
      state <= next_state;
      if (state == S_FETCH && instValid)
        ir <= inst;
    end
  end

  // Outputs stay at zero for the whole time rst is high so an aborted op never writes.
  always_comb begin
    next_state = state;
    instReady  = 1'b0;
    aluSel     = '0;
    regInSel   = '0;
    regOutSel  = '0;
    regInEn    = 1'b0;
    regOutEn   = 1'b0;
    genConst   = 1'b0;
    loadAddr   = 1'b0;
    aluLatch   = 1'b0;
    busy       = 1'b0;
    halted     = 1'b0;
    illegal    = 1'b0;
    if (!rst) begin
      case (state)
        S_FETCH: begin
          instReady = 1'b1;
          if (instValid)
            next_state = S_EXEC1;
        end
        S_EXEC1: begin
          busy       = 1'b1;
          next_state = S_FETCH;
          if (op[OP_W-1]) begin
            regOutEn   = 1'b1;
            regOutSel  = r;
            aluLatch   = 1'b1;
            next_state = S_EXEC2;
          end else begin
            case (op)
              OP_NOP: ;
              OP_MOV_RR: begin
                regOutEn  = 1'b1;
                regOutSel = r;
                regInEn   = 1'b1;
              end
              OP_MOV_R0: begin
                regOutEn = 1'b1;
                regInEn  = 1'b1;
                regInSel = r;
              end
              OP_LDI: begin
                // Immediate word is taken straight off inst; wait here until it arrives.
                instReady = 1'b1;
                regInSel  = r;
                genConst  = instValid;
                regInEn   = instValid;
                if (!instValid)
                  next_state = S_EXEC1;
              end
              OP_LDA: begin
                regOutEn  = 1'b1;
                regOutSel = r;
                loadAddr  = 1'b1;
              end
              OP_HLT: next_state = S_HALT;
              default: illegal = 1'b1;
            endcase
          end
        end
        S_EXEC2: begin
          busy       = 1'b1;
          aluSel     = op[ALU_SEL_W-1:0];
          regInEn    = 1'b1;
          next_state = S_FETCH;
        end
        default: begin
          halted = 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_control_unit.sv
// tb/tb_seq_control_unit.sv - directed and randomized checks of seq_control_unit
// Reference model tracks the current instruction and its execute step, not the RTL state.
module tb_seq_control_unit;

  logic       clk;
  logic       rst;
  logic [7:0] inst;
  logic       instValid;
  logic       instReady;
  logic [3:0] aluSel;
  logic [2:0] regInSel;
  logic [2:0] regOutSel;
  logic       regInEn;
  logic       regOutEn;
  logic       genConst;
  logic       loadAddr;
  logic       aluLatch;
  logic       busy;
  logic       halted;
  logic       illegal;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] m_ir = 8'd0;
  int         m_step = 0;
  bit         m_halt = 1'b0;

  seq_control_unit #(.INST_W(8), .REG_SEL_W(3), .ALU_SEL_W(4)) dut (
    .clk(clk), .rst(rst), .inst(inst), .instValid(instValid), .instReady(instReady),
    .aluSel(aluSel), .regInSel(regInSel), .regOutSel(regOutSel), .regInEn(regInEn),
    .regOutEn(regOutEn), .genConst(genConst), .loadAddr(loadAddr), .aluLatch(aluLatch),
    .busy(busy), .halted(halted), .illegal(illegal)
  );

  always #5 clk = ~clk;

  function automatic logic [18:0] obs();
    return {instReady, aluSel, regInSel, regOutSel, regInEn, regOutEn,
            genConst, loadAddr, aluLatch, busy, halted, illegal};
  endfunction

  // Expected outputs for the current cycle, from the instruction table.
  function automatic logic [18:0] model_out();
    logic [4:0] op;
    logic [2:0] rr;
    logic       rdy, ie, oe, gc, la, al, bsy, hl, il;
    logic [3:0] a;
    logic [2:0] ri, ro;
    op = m_ir[7:3];
    rr = m_ir[2:0];
    {rdy, a, ri, ro, ie, oe, gc, la, al, bsy, hl, il} = '0;
    if (rst) return '0;
    if (m_halt) hl = 1'b1;
    else if (m_step == 0) rdy = 1'b1;
    else if (m_step == 2) begin
      bsy = 1'b1; a = op[3:0]; ie = 1'b1;
    end else begin
      bsy = 1'b1;
      if (op[4]) begin
        oe = 1'b1; ro = rr; al = 1'b1;
      end else begin
        case (op)
          5'd1: begin oe = 1'b1; ro = rr; ie = 1'b1; end
          5'd2: begin oe = 1'b1; ie = 1'b1; ri = rr; end
          5'd3: begin rdy = 1'b1; ri = rr; gc = instValid; ie = instValid; end
          5'd4: begin oe = 1'b1; ro = rr; la = 1'b1; end
          5'd0, 5'd7: begin end
          default: il = 1'b1;
        endcase
      end
    end
    return {rdy, a, ri, ro, ie, oe, gc, la, al, bsy, hl, il};
  endfunction

  task automatic model_update();
    if (rst) begin
      m_ir = 8'd0; m_step = 0; m_halt = 1'b0;
    end else if (m_halt) begin
    end else if (m_step == 0) begin
      if (instValid) begin m_ir = inst; m_step = 1; end
    end else if (m_step == 2) m_step = 0;
    else if (m_ir[7]) m_step = 2;
    else if (m_ir[7:3] == 5'd3 && !instValid) m_step = 1;
    else if (m_ir[7:3] == 5'd7) begin m_halt = 1'b1; m_step = 0; end
    else m_step = 0;
  endtask

  task automatic drive(input logic [7:0] w, input logic v, input logic r);
    inst = w; instValid = v; rst = r;
    #2;
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      drive(8'hFF, 1'b1, 1'b1);
      vectors++;
      if (obs() !== 19'd0) begin
        miscompares++;
        $display("FAIL reset_outputs: got %h expected 0", obs());
      end
      tick();
    end
    for (int i = 0; i < 2; i++) begin
      drive(8'hFF, 1'b0, 1'b0);
      vectors++;
      if (instReady !== 1'b1 || busy !== 1'b0 || halted !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_release: got ready=%b busy=%b halted=%b expected 1 0 0", instReady, busy, halted);
      end
      tick();
    end
  endtask

  task automatic test_mov();
    drive(8'b00001_011, 1'b1, 1'b0);
    tick();
    drive(8'h00, 1'b0, 1'b0);
    vectors++;
    if (regOutSel !== 3'd3 || regOutEn !== 1'b1 || regInSel !== 3'd0 || regInEn !== 1'b1 ||
        aluSel !== 4'd0 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL mov_exec1: got %h expected outsel=3 outen=1 insel=0 inen=1 alu=0 busy=1", obs());
    end
    tick();
    vectors++;
    if (instReady !== 1'b1 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL mov_refetch: got ready=%b busy=%b expected 1 0", instReady, busy);
    end
  endtask

  task automatic test_ldi();
    drive(8'b00011_101, 1'b1, 1'b0);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(8'h00, 1'b0, 1'b0);
      vectors++;
      if (genConst !== 1'b0 || regInEn !== 1'b0 || instReady !== 1'b1 || busy !== 1'b1) begin
        miscompares++;
        $display("FAIL ldi_wait: got gc=%b inen=%b ready=%b busy=%b expected 0 0 1 1", genConst, regInEn, instReady, busy);
      end
      tick();
    end
    drive(8'h5A, 1'b1, 1'b0);
    vectors++;
    if (genConst !== 1'b1 || regInEn !== 1'b1 || regInSel !== 3'd5 || instReady !== 1'b1) begin
      miscompares++;
      $display("FAIL ldi_imm: got gc=%b inen=%b insel=%0d ready=%b expected 1 1 5 1", genConst, regInEn, regInSel, instReady);
    end
    tick();
    drive(8'h00, 1'b0, 1'b0);
    vectors++;
    if (instReady !== 1'b1 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL ldi_done: got ready=%b busy=%b expected 1 0", instReady, busy);
    end
  endtask

  task automatic test_alu();
    drive(8'b1_0110_010, 1'b1, 1'b0);
    tick();
    drive(8'h00, 1'b0, 1'b0);
    vectors++;
    if (aluLatch !== 1'b1 || regOutSel !== 3'd2 || regOutEn !== 1'b1 || regInEn !== 1'b0 || aluSel !== 4'd0) begin
      miscompares++;
      $display("FAIL alu_exec1: got %h expected latch=1 outsel=2 outen=1 inen=0 alu=0", obs());
    end
    tick();
    vectors++;
    if (aluSel !== 4'd6 || regInEn !== 1'b1 || regInSel !== 3'd0 || regOutEn !== 1'b0 || aluLatch !== 1'b0) begin
      miscompares++;
      $display("FAIL alu_exec2: got %h expected alu=6 inen=1 insel=0 outen=0 latch=0", obs());
    end
    tick();
    vectors++;
    if (instReady !== 1'b1 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL alu_refetch: got ready=%b busy=%b expected 1 0", instReady, busy);
    end
  endtask

  task automatic test_illegal_halt();
    drive(8'b00101_000, 1'b1, 1'b0);
    tick();
    drive(8'h00, 1'b0, 1'b0);
    vectors++;
    if (obs() !== {1'b0, 4'd0, 3'd0, 3'd0, 6'b000001, 1'b0, 1'b1}) begin
      miscompares++;
      $display("FAIL illegal_exec1: got %h expected only busy and illegal set", obs());
    end
    tick();
    vectors++;
    if (illegal !== 1'b0 || instReady !== 1'b1) begin
      miscompares++;
      $display("FAIL illegal_pulse: got illegal=%b ready=%b expected 0 1", illegal, instReady);
    end
    drive(8'b00111_000, 1'b1, 1'b0);
    tick();
    tick();
    for (int i = 0; i < 10; i++) begin
      drive(8'($urandom), 1'b1, 1'b0);
      vectors++;
      if (halted !== 1'b1 || instReady !== 1'b0 || busy !== 1'b0 || regInEn !== 1'b0) begin
        miscompares++;
        $display("FAIL halt_hold: got halted=%b ready=%b busy=%b inen=%b expected 1 0 0 0", halted, instReady, busy, regInEn);
      end
      tick();
    end
    drive(8'h00, 1'b0, 1'b1);
    tick();
    drive(8'h00, 1'b0, 1'b0);
    vectors++;
    if (halted !== 1'b0 || instReady !== 1'b1) begin
      miscompares++;
      $display("FAIL halt_exit: got halted=%b ready=%b expected 0 1", halted, instReady);
    end
  endtask

  task automatic test_reset_mid_alu();
    drive(8'b1_0011_100, 1'b1, 1'b0);
    tick();
    drive(8'h00, 1'b0, 1'b0);
    tick();
    drive(8'h00, 1'b0, 1'b0);
    vectors++;
    if (regInEn !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_alu_pre: got inen=%b expected 1", regInEn);
    end
    rst = 1'b1;
    #1;
    vectors++;
    if (regInEn !== 1'b0 || obs() !== 19'd0) begin
      miscompares++;
      $display("FAIL mid_alu_abort: got %h expected 0", obs());
    end
    tick();
    drive(8'b00010_110, 1'b1, 1'b0);
    tick();
    drive(8'h00, 1'b0, 1'b0);
    vectors++;
    if (regInSel !== 3'd6 || regOutSel !== 3'd0 || regInEn !== 1'b1 || regOutEn !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_alu_after: got insel=%0d outsel=%0d inen=%b outen=%b expected 6 0 1 1", regInSel, regOutSel, regInEn, regOutEn);
    end
    tick();
  endtask

  task automatic test_random();
    logic [4:0] ops [10];
    logic [4:0] op;
    logic       r;
    ops = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd7, 5'd5, 5'd16, 5'd25, 5'd31};
    for (int i = 0; i < 600; i++) begin
      op = ops[$urandom_range(0, 9)];
      if ($urandom_range(0, 3) == 0) op = 5'($urandom);
      r = ($urandom_range(0, 39) == 0) || (m_halt && $urandom_range(0, 5) == 0);
      drive({op, 3'($urandom)}, $urandom_range(0, 9) < 7, r);
      vectors++;
      if (obs() !== model_out()) begin
        miscompares++;
        $display("FAIL random_cycle%0d: got %h expected %h", i, obs(), model_out());
      end
      tick();
    end
  endtask

  initial begin
    clk = 1'b0;
    rst = 1'b1;
    inst = 8'hFF;
    instValid = 1'b1;
    tick();
    test_reset();
    test_mov();
    test_ldi();
    test_alu();
    test_illegal_halt();
    test_reset_mid_alu();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
